// File: rtl/rom_access_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-read-port combinational ROM.
// Optional single-entry fetch prefetch buffer: define ROM_FETCH_PREFETCH_EN.
module rom_access_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

`ifdef ROM_FETCH_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, READ, RESP, PF_READ} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
`endif

  state_t state;
  logic   own_d;          // owner of the read in flight: 1 = D, 0 = F
  logic   last_winner_d;  // winner of the most recent contention
  logic   can_grant;
  logic   f_hit;
  logic   contend;
  logic   d_wins;

`ifdef ROM_FETCH_PREFETCH_EN
  logic [ADDR_W-1:0] pf_addr;
  logic [DATA_W-1:0] pf_data;
  logic              pf_valid;
  logic [ADDR_W-1:0] last_f_addr;
  logic              last_gnt_f;
  logic [ADDR_W-1:0] next_pf_addr;
  logic              pf_start;

  assign next_pf_addr = last_f_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign f_hit        = pf_valid && f_req && (f_addr == pf_addr);
  // Prefetch once per idle stretch; skip if the buffer already holds the next word.
  assign pf_start     = (state == IDLE) && !f_req && !d_req && last_gnt_f &&
                        !(pf_valid && (pf_addr == next_pf_addr));
`else
  assign f_hit = 1'b0;
`endif

  assign can_grant = (state == IDLE) || (state == RESP);
  // A prefetch hit never touches the ROM, so it cannot contend with D.
  assign contend   = f_req && !f_hit && d_req;
  assign d_wins    = !last_winner_d;
  assign f_gnt     = can_grant && f_req && (!contend || !d_wins);
  assign d_gnt     = can_grant && d_req && (!contend || d_wins);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= IDLE;
      own_d         <= 1'b0;
      last_winner_d <= 1'b0;
      f_rvalid      <= 1'b0;
      d_rvalid      <= 1'b0;
      f_rdata       <= '0;
      d_rdata       <= '0;
      rom_addr      <= '0;
`ifdef ROM_FETCH_PREFETCH_EN
      pf_addr       <= '0;
      pf_data       <= '0;
      pf_valid      <= 1'b0;
      last_f_addr   <= '0;
      last_gnt_f    <= 1'b0;
`endif
    end else begin
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (can_grant && contend) last_winner_d <= d_wins;
      case (state)
        READ: begin
          if (own_d) begin
            d_rvalid <= 1'b1;
            d_rdata  <= rom_data;
          end else begin
            f_rvalid <= 1'b1;
            f_rdata  <= rom_data;
          end
          state <= RESP;
        end
`ifdef ROM_FETCH_PREFETCH_EN
        PF_READ: begin
          pf_data  <= rom_data;
          pf_addr  <= rom_addr;
          pf_valid <= 1'b1;
          state    <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
`ifdef ROM_FETCH_PREFETCH_EN
          if (f_hit) begin
            f_rvalid    <= 1'b1;
            f_rdata     <= pf_data;
            last_f_addr <= f_addr;
            last_gnt_f  <= 1'b1;
          end
`endif
          if (d_gnt) begin
            own_d    <= 1'b1;
            rom_addr <= d_addr;
            state    <= READ;
`ifdef ROM_FETCH_PREFETCH_EN
            last_gnt_f <= 1'b0;
`endif
          end else if (f_gnt && !f_hit) begin
            own_d    <= 1'b0;
            rom_addr <= f_addr;
            state    <= READ;
`ifdef ROM_FETCH_PREFETCH_EN
            pf_valid    <= 1'b0;
            last_f_addr <= f_addr;
            last_gnt_f  <= 1'b1;
`endif
          end
`ifdef ROM_FETCH_PREFETCH_EN
          else if (pf_start) begin
            rom_addr <= next_pf_addr;
            state    <= PF_READ;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Scoreboard bench for rom_access_arbiter: directed cases then randomized two-port traffic.
module tb_rom_access_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          f_req = 1'b0, d_req = 1'b0;
  logic [AW-1:0] f_addr = '0, d_addr = '0;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] f_rdata, d_rdata, rom_data;
  logic [AW-1:0] rom_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t fq[$];
  exp_t dq[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  function automatic logic [DW-1:0] rom_word(logic [AW-1:0] a);
    case (a)
      16'h0000: return 32'h00008006;
      16'h0001: return 32'h00030054;
      16'h0003: return 32'h00010006;
      default:  return {a ^ 16'hA5C3, ~a};
    endcase
  endfunction

  assign rom_data = rom_word(rom_addr);

  rom_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: round-robin reference, busy/free grant rules and per-port data scoreboard.
  bit   lw_d;
  bit   prev_gnt;
  exp_t e;
  initial forever begin
    @(negedge CLK);
    if (!mon_en) begin
      fq.delete();
      dq.delete();
      lw_d     = 1'b0;
      prev_gnt = 1'b0;
    end else begin
      chk("rvalid_both", {63'd0, f_rvalid && d_rvalid}, 64'd0);
      if (f_rvalid) begin
        if (fq.size() == 0) chk("f_rvalid_unexpected", 64'd1, 64'd0);
        else begin
          e = fq.pop_front();
          chk("f_rdata", f_rdata, e.data);
`ifndef ROM_FETCH_PREFETCH_EN
          chk("f_latency", cyc, e.due);
`endif
        end
      end else if (fq.size() > 0 && fq[0].due < cyc) begin
        chk("f_rvalid_missing", 64'd0, 64'd1);
        void'(fq.pop_front());
      end
      if (d_rvalid) begin
        if (dq.size() == 0) chk("d_rvalid_unexpected", 64'd1, 64'd0);
        else begin
          e = dq.pop_front();
          chk("d_rdata", d_rdata, e.data);
          chk("d_latency", cyc, e.due);
        end
      end else if (dq.size() > 0 && dq[0].due < cyc) begin
        chk("d_rvalid_missing", 64'd0, 64'd1);
        void'(dq.pop_front());
      end
      if (f_gnt) begin
        chk("f_gnt_without_req", {63'd0, f_req}, 64'd1);
        fq.push_back('{rom_word(f_addr), cyc + 2});
      end
      if (d_gnt) begin
        chk("d_gnt_without_req", {63'd0, d_req}, 64'd1);
        dq.push_back('{rom_word(d_addr), cyc + 2});
      end
`ifndef ROM_FETCH_PREFETCH_EN
      chk("gnt_both", {63'd0, f_gnt && d_gnt}, 64'd0);
      if (prev_gnt) chk("gnt_while_busy", {63'd0, f_gnt || d_gnt}, 64'd0);
      else if (f_req || d_req) chk("gnt_when_free", {63'd0, f_gnt || d_gnt}, 64'd1);
      if (f_req && d_req && (f_gnt || d_gnt)) begin
        chk("rr_d_wins", {63'd0, d_gnt}, {63'd0, !lw_d});
        lw_d = d_gnt;
      end
`endif
      prev_gnt = f_gnt || d_gnt;
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Raise the selected requests and hold each until its grant is seen.
  task automatic issue(bit fe, logic [AW-1:0] fa, bit de, logic [AW-1:0] da);
    bit fd = !fe;
    bit dd = !de;
    int n  = 0;
    f_req = fe; f_addr = fa;
    d_req = de; d_addr = da;
    while (!(fd && dd) && n < 20) begin
      @(negedge CLK);
      n++;
      if (f_gnt) fd = 1'b1;
      if (d_gnt) dd = 1'b1;
      @(posedge CLK);
      #1;
      if (fd) f_req = 1'b0;
      if (dd) d_req = 1'b0;
    end
    chk("grant_done", {62'd0, fd, dd}, 64'd3);
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] last_fa = '0;
  logic [AW-1:0] fa, da;
  bit            fe, de;

  initial begin
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_f_rvalid", {63'd0, f_rvalid}, 64'd0);
    chk("rst_d_rvalid", {63'd0, d_rvalid}, 64'd0);
    chk("rst_f_rdata", f_rdata, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_rom_addr", rom_addr, 64'd0);
    chk("rst_gnt", {62'd0, f_gnt, d_gnt}, 64'd0);
    @(posedge CLK);
    #1;
    RST_N  = 1'b1;
    mon_en = 1'b1;

    issue(1'b1, 16'h0003, 1'b0, 16'h0000); idle(3);
    issue(1'b1, 16'h0000, 1'b1, 16'h0001); idle(3);
    issue(1'b1, 16'h0005, 1'b0, 16'h0000);
    issue(1'b1, 16'h0006, 1'b0, 16'h0000); idle(3);
    issue(1'b1, 16'hFFFF, 1'b0, 16'h0000); idle(6);
    issue(1'b1, 16'h0000, 1'b0, 16'h0000); idle(3);
    issue(1'b0, 16'h0000, 1'b1, 16'hFFFF); idle(2);

    repeat (300) begin
      fe = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 1));
      if (!fe && !de) fe = 1'b1;
      if ($urandom_range(0, 3) == 0) fa = last_fa + 16'd1;
      else if ($urandom_range(0, 1) == 0) fa = 16'($urandom_range(0, 7));
      else fa = 16'($urandom);
      da = 16'($urandom);
      if (fe) last_fa = fa;
      issue(fe, fa, de, da);
      idle($urandom_range(0, 4));
    end

    // Reset arriving while the D read is in flight must drop the response.
    idle(6);
    mon_en = 1'b0;
    d_req  = 1'b1;
    d_addr = 16'h0012;
    @(negedge CLK);
    chk("rst_mid_d_gnt", {63'd0, d_gnt}, 64'd1);
    @(posedge CLK);
    #1;
    d_req = 1'b0;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N  = 1'b1;
    f_req  = 1'b1;
    f_addr = 16'h0003;
    @(negedge CLK);
    chk("rst_mid_no_d_rvalid", {63'd0, d_rvalid}, 64'd0);
    chk("rst_mid_d_rdata", d_rdata, 64'd0);
    chk("rst_mid_idle_f_gnt", {63'd0, f_gnt}, 64'd1);
    @(posedge CLK);
    #1;
    f_req = 1'b0;
    @(negedge CLK);
    chk("rst_mid_no_d_rvalid2", {63'd0, d_rvalid}, 64'd0);
    @(negedge CLK);
    chk("rst_mid_f_rvalid", {63'd0, f_rvalid}, 64'd1);
    chk("rst_mid_f_rdata", f_rdata, 64'h00010006);
    idle(6);
    mon_en = 1'b1;

    repeat (40) begin
      fe = 1'($urandom_range(0, 1));
      de = !fe || ($urandom_range(0, 1) == 1);
      issue(fe, 16'($urandom_range(0, 15)), de, 16'($urandom_range(0, 15)));
      idle($urandom_range(0, 2));
    end
    idle(8);
    chk("f_queue_drained", 64'(fq.size()), 64'd0);
    chk("d_queue_drained", 64'(dq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
